vector_u_driver: RTL
====================

# vector_u_driver

Host-side sequencer that drives the `vector_U` URAM vector unit through its raw host port. It accepts one operation per command handshake (two 256-bit operands plus `mod`) and writes the operands into the slots the unit's internal read counter will fetch next. It then pulses `en_read`, waits the unit's fixed pipeline latency, captures the result from result slot 0x20, and returns it on a valid/ready response channel. It sits between the host command FIFO and `vector_U`, sharing that unit's clock and reset.

## Interface
- `Size`, 256: operand/result width
- `LAT`, 14: cycles from the `en_read` pulse cycle to the `out_number` capture cycle
- `clk`  in  1: sole clock
- `rst`  in  1: reset, asynchronous and active-low
- `cmd_valid`  in  1: command offered
- `cmd_ready`  out  1: command accepted when both high
- `cmd_mod`  in  2: 00 A+B, 01 A−B, 10 B, 11 A
- `cmd_a`, `cmd_b`  in  Size: operands
- `rsp_valid`  out  1: result available
- `rsp_ready`  in  1: result consumed when both high
- `rsp_data`  out  Size: result
- `exhausted`  out  1: operand slot space used up; sticky until reset
- `data_in`  out  Size: to unit
- `host_write_addr`  out  6: to unit
- `host_read_addr`  out  6: to unit
- `mod`  out  2: to unit
- `en_read`  out  1: to unit
- `out_number`  in  Size: from unit

## Operation
- **Slot pointer `ptr`** (6 bit, reset 0):
  - Mirrors the unit's internal read counter.
  - Operand A goes to `ptr+1`, operand B to `ptr+2`.
  - `ptr += 2` at the START state.
- **Idle outputs:** when not loading, `host_write_addr` = 0 (park address) and `data_in` = 0.
  - The unit writes every cycle, so address 0 is continuously overwritten with zeros.
- **`host_read_addr`** is driven to 0x20 at all times after reset.
  - The unit's write-back lands at 0x20 + park address = 0x20.
- **States** (all outputs registered):
  - IDLE: `cmd_ready`=1 unless `exhausted`. On accept, latch A, B, `cmd_mod` → LOAD_A.
  - LOAD_A: `host_write_addr`=`ptr+1`, `data_in`=A, `mod`=latched mod → LOAD_B.
  - LOAD_B: `host_write_addr`=`ptr+2`, `data_in`=B → START.
  - START: park outputs; `en_read`=1 for exactly this cycle; `ptr+=2`; counter ← `LAT−1` → RUN.
  - RUN: count down; `mod` held stable. At 0: `rsp_data` ← `out_number`, `rsp_valid`=1 → RESP.
  - RESP: hold `rsp_data`/`rsp_valid` until `rsp_ready`, then → IDLE. Set `exhausted` if `ptr` > 0x1C.
- **Exhaustion:**
  - `ptr` ≤ 0x1C keeps operands in 1..0x1E, clear of 0 and 0x20. This allows exactly 15 operations per reset.
  - Once exhausted, `cmd_ready` stays 0; only `rst` clears it.
- **Arithmetic:** performed in the unit, mod 2^Size. The driver does no arithmetic besides `ptr` and the counter.
- **Reset values:** `cmd_ready` 0, `rsp_valid` 0, `rsp_data` 0, `exhausted` 0, `data_in` 0, `host_write_addr` 0, `host_read_addr` 0x20, `mod` 0, `en_read` 0, state IDLE.
  - `cmd_ready` rises the first cycle after reset release.

## Timing
- Command accepted at edge T:
  - LOAD_A occupies cycle T+1, LOAD_B T+2.
  - `en_read` is high during T+3.
  - Capture occurs at edge T+3+`LAT`; `rsp_valid` is high from T+4+`LAT`.
- Earliest next accept is the cycle after `rsp_valid`&`rsp_ready`, so there is at most one operation in flight.
- `cmd_ready` is low from LOAD_A through RESP; commands offered then are held off, not dropped.
- Asserting `rst` mid-operation:
  - Immediately returns all outputs to reset values and clears `ptr`.
  - `rst` must also reset the unit so both counters realign.
- `rsp_ready` held high in RESP completes the handshake in one cycle. `rsp_data` must not change while `rsp_valid`=1.

## Structure
- Shared package `vector_u_pkg`:
  - State encoding (IDLE, LOAD_A, LOAD_B, START, RUN, RESP).
  - `PARK_ADDR`=6'd0, `RES_ADDR`=6'h20, `PTR_LIMIT`=6'h1C.
  - `mod` codes.
- Single flat module; no sub-module needed.
- The integration wrapper `vector_u_sys` instantiates the driver plus `vector_U`.

## Test plan
- **Reset:**
  - Stimulus: hold `rst`=0 for 5 cycles, then release.
  - Check: all outputs at reset values; `host_read_addr`=0x20; `cmd_ready`=1 one cycle after release.
- **Add:**
  - Stimulus: `cmd_mod`=00, A=5, B=7, `rsp_ready`=1.
  - Check: writes to addresses 1 and 2; one-cycle `en_read` at T+3; `rsp_data`=12 at T+4+`LAT`.
- **Subtract wrap:**
  - Stimulus: `cmd_mod`=01, A=3, B=5.
  - Check: `rsp_data`=2^256−2; operands written to 3 and 4.
- **Pass-through and backpressure:**
  - Stimulus: `cmd_mod`=10, A=0xAA, B=0x55; `rsp_ready`=0 for 6 cycles.
  - Check: `rsp_data`=0x55 held stable with `rsp_valid`=1; `cmd_ready`=0 throughout.
- **Exhaustion:**
  - Stimulus: 16 back-to-back `cmd_mod`=11 commands with A=i.
  - Check: 15 responses equal to i; `exhausted`=1 after the 15th; 16th never accepted.
- **Reset mid-RUN:**
  - Stimulus: assert `rst` during RUN of op 2.
  - Check: no response; next op uses slots 1 and 2 and returns the correct sum.

Source files
------------

// File: rtl/vector_u_pkg.sv
// rtl/vector_u_pkg.sv - shared encodings and slot constants for the vector_U host driver
package vector_u_pkg;

  // Sequencer states, one operation in flight at a time
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_START  = 3'd3,
    ST_RUN    = 3'd4,
    ST_RESP   = 3'd5
  } drv_state_e;

  // Idle write address; the unit writes every cycle, so this slot is scratch
  localparam logic [5:0] PARK_ADDR = 6'd0;
  // Result slot: unit write-back lands at 0x20 + park address
  localparam logic [5:0] RES_ADDR  = 6'h20;
  // Largest pointer that still keeps both operand slots inside 1..0x1E
  localparam logic [5:0] PTR_LIMIT = 6'h1C;

  // Operation codes understood by the unit
  localparam logic [1:0] MOD_ADD  = 2'b00;
  localparam logic [1:0] MOD_SUB  = 2'b01;
  localparam logic [1:0] MOD_B    = 2'b10;
  localparam logic [1:0] MOD_A    = 2'b11;

endpackage

// File: rtl/vector_u_driver.sv
// rtl/vector_u_driver.sv - host-side sequencer feeding operands to vector_U and returning its result
module vector_u_driver
  import vector_u_pkg::*;
#(
  parameter int Size = 256,
  parameter int LAT  = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_mod,
  input  logic [Size-1:0] cmd_a,
  input  logic [Size-1:0] cmd_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [Size-1:0] rsp_data,
  output logic            exhausted,
  output logic [Size-1:0] data_in,
  output logic [5:0]      host_write_addr,
  output logic [5:0]      host_read_addr,
  output logic [1:0]      mod,
  output logic            en_read,
  input  logic [Size-1:0] out_number
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  drv_state_e      state_q, state_d;
  logic [5:0]      ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [Size-1:0] b_q, b_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [Size-1:0] rsp_data_q, rsp_data_d;
  logic            exhausted_q, exhausted_d;
  logic [Size-1:0] data_in_q, data_in_d;
  logic [5:0]      waddr_q, waddr_d;
  logic [1:0]      mod_q, mod_d;
  logic            en_read_q, en_read_d;

  // Next state plus next values of every registered output (outputs follow state_d)
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    b_d         = b_q;
    rsp_data_d  = rsp_data_q;
    exhausted_d = exhausted_q;
    mod_d       = mod_q;
    waddr_d     = PARK_ADDR;
    data_in_d   = '0;
    en_read_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = ST_LOAD_A;
          waddr_d   = ptr_q + 6'd1;
          data_in_d = cmd_a;
          mod_d     = cmd_mod;
          b_d       = cmd_b;
        end
      end
      ST_LOAD_A: begin
        state_d   = ST_LOAD_B;
        waddr_d   = ptr_q + 6'd2;
        data_in_d = b_q;
      end
      ST_LOAD_B: begin
        state_d   = ST_START;
        en_read_d = 1'b1;
      end
      ST_START: begin
        state_d = ST_RUN;
        ptr_d   = ptr_q + 6'd2;
        cnt_d   = CW'(LAT - 1);
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          rsp_data_d = out_number;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          if (ptr_q > PTR_LIMIT) begin
            exhausted_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RESP);
    cmd_ready_d = (state_d == ST_IDLE) && !exhausted_d;
  end

  // State and output registers; reset parks everything and realigns the slot pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      b_q         <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      exhausted_q <= 1'b0;
      data_in_q   <= '0;
      waddr_q     <= PARK_ADDR;
      mod_q       <= 2'b00;
      en_read_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      b_q         <= b_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      exhausted_q <= exhausted_d;
      data_in_q   <= data_in_d;
      waddr_q     <= waddr_d;
      mod_q       <= mod_d;
      en_read_q   <= en_read_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign exhausted       = exhausted_q;
  assign data_in         = data_in_q;
  assign host_write_addr = waddr_q;
  assign host_read_addr  = RES_ADDR;
  assign mod             = mod_q;
  assign en_read         = en_read_q;

endmodule
